xor_keystream_gen: RTL and testbench

//  Upstream stage of the XOR cipher: produces the keystream bit that the cipher XORs with plaintext.

---
 rtl/xor_cipher_pkg.sv | 24 ++
 rtl/xor_heartbeat.sv | 19 +
 rtl/xor_keystream_gen.sv | 96 +++++++++
 tb/tb_xor_keystream_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the XOR cipher blocks: keystream FSM states, default widths,
// and the Galois LFSR step function that both encrypt and decrypt sides use.
package xor_cipher_pkg;

  localparam int KS_WIDTH   = 8;
  localparam int HB_WIDTH   = 4;
  localparam int LFSR_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } ks_state_t;

  // Vectors are zero-extended to LFSR_MAX_W, so callers of any narrower width
  // can truncate the result without losing tap feedback.
  function automatic logic [LFSR_MAX_W-1:0] galois_step(
    input logic [LFSR_MAX_W-1:0] lfsr,
    input logic [LFSR_MAX_W-1:0] taps
  );
    galois_step = (lfsr >> 1) ^ (lfsr[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/xor_heartbeat.sv
// Free-running liveness counter; the heartbeat is the counter MSB.
module xor_heartbeat #(
  parameter int HB_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic heartbeat
);

  logic [HB_DIV-1:0] hb_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hb_cnt <= '0;
    else     hb_cnt <= hb_cnt + HB_DIV'(1);
  end

  assign heartbeat = hb_cnt[HB_DIV-1];

endmodule

// File: rtl/xor_keystream_gen.sv
// Keystream source for the XOR cipher: serially configured Galois LFSR whose output
// bit is offered over valid/ready, with all-zero lock-up detection and a heartbeat.
module xor_keystream_gen
  import xor_cipher_pkg::*;
#(
  parameter int WIDTH  = KS_WIDTH,
  parameter int HB_DIV = HB_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic cfg_en,
  input  logic cfg_i,
  output logic cfg_o,
  input  logic start,
  input  logic ks_ready,
  output logic ks_valid,
  output logic ks_bit,
  output logic locked_zero,
  output logic heartbeat
);

  logic [2*WIDTH-1:0] cfg_reg;
  logic [WIDTH-1:0]   taps;
  logic [WIDTH-1:0]   seed;
  logic [WIDTH-1:0]   lfsr;
  logic [WIDTH-1:0]   nxt;
  ks_state_t          state;

  assign taps = cfg_reg[2*WIDTH-1:WIDTH];
  assign seed = cfg_reg[WIDTH-1:0];
  assign nxt  = WIDTH'(galois_step(LFSR_MAX_W'(lfsr), LFSR_MAX_W'(taps)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cfg_reg <= '0;
    else if (cfg_en) cfg_reg <= {cfg_reg[2*WIDTH-2:0], cfg_i};
  end

  assign cfg_o  = cfg_reg[2*WIDTH-1];
  assign ks_bit = lfsr[0];

  // Any config activity aborts generation, so a transfer in flight that cycle is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr        <= '0;
      state       <= IDLE;
      ks_valid    <= 1'b0;
      locked_zero <= 1'b0;
    end else if (cfg_en) begin
      state       <= IDLE;
      ks_valid    <= 1'b0;
      locked_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (seed != '0) begin
              lfsr     <= seed;
              state    <= RUN;
              ks_valid <= 1'b1;
            end else begin
              state       <= FAULT;
              locked_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          if (ks_valid && ks_ready) begin
            if (nxt == '0) begin
              lfsr        <= '0;
              state       <= FAULT;
              ks_valid    <= 1'b0;
              locked_zero <= 1'b1;
            end else begin
              lfsr <= nxt;
            end
          end
        end
        FAULT: begin
          ks_valid    <= 1'b0;
          locked_zero <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          ks_valid <= 1'b0;
        end
      endcase
    end
  end

  xor_heartbeat #(.HB_DIV(HB_DIV)) u_heartbeat (
    .clk       (clk),
    .rst       (rst),
    .heartbeat (heartbeat)
  );

endmodule

// File: tb/tb_xor_keystream_gen.sv
// Scoreboard bench for xor_keystream_gen: expected keystream bits are queued when a
// stream is started and popped as each handshake completes.
module tb_xor_keystream_gen;

  logic clk;
  logic rst;
  logic cfg_en;
  logic cfg_i;
  logic cfg_o;
  logic start;
  logic ks_ready;
  logic ks_valid;
  logic ks_bit;
  logic locked_zero;
  logic heartbeat;

  int errors = 0;
  int checks = 0;
  logic exp_q[$];

  xor_keystream_gen #(.WIDTH(8), .HB_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_en      (cfg_en),
    .cfg_i       (cfg_i),
    .cfg_o       (cfg_o),
    .start       (start),
    .ks_ready    (ks_ready),
    .ks_valid    (ks_valid),
    .ks_bit      (ks_bit),
    .locked_zero (locked_zero),
    .heartbeat   (heartbeat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Independent reference model of one Galois shift.
  function automatic logic [7:0] modelStep(input logic [7:0] s, input logic [7:0] t);
    logic [7:0] r;
    r = {1'b0, s[7:1]};
    if (s[0]) r = r ^ t;
    return r;
  endfunction

  task automatic resetDut();
    rst = 1'b1; cfg_en = 1'b0; cfg_i = 1'b0; start = 1'b0; ks_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic loadConfig(input logic [7:0] taps, input logic [7:0] seed);
    logic [15:0] word;
    word = {taps, seed};
    for (int i = 15; i >= 0; i--) begin
      cfg_en = 1'b1;
      cfg_i  = word[i];
      @(negedge clk);
    end
    cfg_en = 1'b0;
    cfg_i  = 1'b0;
  endtask

  // Starts a stream, then accepts nbits transfers; ks_ready is withheld for
  // stall_len cycles once stall_at bits have been taken.
  task automatic applyStimulus(input logic [7:0] taps, input logic [7:0] seed,
                               input int nbits, input int stall_at, input int stall_len);
    logic [7:0] m;
    int sent;
    int stalled;
    m = seed;
    sent = 0;
    stalled = 0;
    for (int i = 0; i < nbits; i++) begin
      exp_q.push_back(m[0]);
      m = modelStep(m, taps);
    end
    start = 1'b1;
    ks_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("first_valid", {31'd0, ks_valid}, 32'd1);
    for (int cyc = 0; cyc < 100 && exp_q.size() > 0; cyc++) begin
      if (sent == stall_at && stalled < stall_len) begin
        ks_ready = 1'b0;
        stalled++;
        checkOutput("stall_valid", {31'd0, ks_valid}, 32'd1);
        checkOutput("stall_bit", {31'd0, ks_bit}, {31'd0, exp_q[0]});
      end else begin
        ks_ready = 1'b1;
        checkOutput("run_valid", {31'd0, ks_valid}, 32'd1);
        checkOutput("ks_bit", {31'd0, ks_bit}, {31'd0, exp_q.pop_front()});
        sent++;
      end
      @(negedge clk);
    end
    ks_ready = 1'b0;
    checkOutput("stream_done", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [15:0] pattern;
    rst = 1'b1; cfg_en = 1'b0; cfg_i = 1'b0; start = 1'b0; ks_ready = 1'b0;

    $display("[TB] reset state and heartbeat");
    #1;
    checkOutput("rst_outputs", {27'd0, cfg_o, ks_valid, ks_bit, locked_zero, heartbeat}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 7 || k == 8 || k == 15 || k == 16 || k == 24)
        checkOutput($sformatf("heartbeat_%0d", k), {31'd0, heartbeat}, {31'd0, (k % 16) >= 8});
    end
    checkOutput("idle_valid", {31'd0, ks_valid}, 32'd0);

    $display("[TB] full-throughput stream");
    resetDut();
    loadConfig(8'hB8, 8'h01);
    applyStimulus(8'hB8, 8'h01, 6, -1, 0);
    @(negedge clk);
    checkOutput("post_stream_valid", {31'd0, ks_valid}, 32'd1);
    checkOutput("post_stream_lock", {31'd0, locked_zero}, 32'd0);

    $display("[TB] stalled stream");
    resetDut();
    loadConfig(8'hB8, 8'h01);
    applyStimulus(8'hB8, 8'h01, 8, 2, 5);

    $display("[TB] lock-up paths");
    resetDut();
    loadConfig(8'h00, 8'h01);
    applyStimulus(8'h00, 8'h01, 1, -1, 0);
    checkOutput("fault_valid", {31'd0, ks_valid}, 32'd0);
    checkOutput("fault_lock", {31'd0, locked_zero}, 32'd1);
    resetDut();
    loadConfig(8'hB8, 8'h00);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("zero_seed_valid", {31'd0, ks_valid}, 32'd0);
      checkOutput("zero_seed_lock", {31'd0, locked_zero}, 32'd1);
      @(negedge clk);
    end
    cfg_en = 1'b1;
    @(negedge clk);
    cfg_en = 1'b0;
    checkOutput("lock_cleared", {31'd0, locked_zero}, 32'd0);

    $display("[TB] config chain readback");
    resetDut();
    loadConfig(8'hB8, 8'h01);
    pattern = 16'hB801;
    for (int i = 15; i >= 0; i--) begin
      checkOutput($sformatf("cfg_o_%0d", i), {31'd0, cfg_o}, {31'd0, pattern[i]});
      cfg_en = 1'b1;
      cfg_i  = 1'b0;
      @(negedge clk);
    end
    cfg_en = 1'b0;
    checkOutput("cfg_flushed", {31'd0, cfg_o}, 32'd0);

    $display("[TB] config during run");
    resetDut();
    loadConfig(8'hB8, 8'h01);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("run_entered", {31'd0, ks_valid}, 32'd1);
    cfg_en = 1'b1;
    ks_ready = 1'b1;
    @(negedge clk);
    cfg_en = 1'b0;
    ks_ready = 1'b0;
    checkOutput("cfg_abort_valid", {31'd0, ks_valid}, 32'd0);
    checkOutput("cfg_abort_lock", {31'd0, locked_zero}, 32'd0);

    $display("[TB] asynchronous reset mid-run");
    resetDut();
    loadConfig(8'hB8, 8'h01);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("pre_rst_valid", {31'd0, ks_valid}, 32'd1);
    checkOutput("pre_rst_cfg_o", {31'd0, cfg_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst", {29'd0, ks_valid, cfg_o, locked_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("no_reload_lock", {31'd0, locked_zero}, 32'd1);
    checkOutput("no_reload_valid", {31'd0, ks_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
